// File: rtl/arm_dmem_io.sv
// arm_dmem_io: zero-wait-state data memory for the ARM pipeline M stage.
// It holds a word-addressed RAM and a 16-byte I/O window with a byte TX FIFO,
// a status register and a loadable free-running cycle counter.
module arm_dmem_io #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] FULL_COUNT = 5'(FIFO_DEPTH);

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE  = 2'd2;

  // Storage
  logic [31:0] ram [DEPTH_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  // State registers and their next values
  logic [4:0]    count_reg, count_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic          ovf_reg, ovf_next;
  logic [31:0]   cycle_reg, cycle_next;

  // Address decode
  logic          io_sel;
  logic [1:0]    offset;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_bits;

  assign io_sel           = (ALUOutM[31:4] == IO_BASE[31:4]);
  assign offset           = ALUOutM[3:2];
  assign ram_idx          = ALUOutM[AW+1:2];
  assign unused_addr_bits = ^ALUOutM[1:0];

  // Access strobes; stores during reset must not disturb RAM or FIFO contents
  logic ram_we, push_req, push_ok, push_rej, pop, status_clr, cycle_load;
  logic full, empty;

  assign full       = (count_reg == FULL_COUNT);
  assign empty      = (count_reg == 5'd0);
  assign tx_valid   = !empty;
  assign pop        = tx_valid && tx_ready;
  assign ram_we     = MemWriteM && !io_sel && !reset;
  assign push_req   = MemWriteM && io_sel && (offset == OFF_TXDATA);
  assign push_ok    = push_req && (!full || pop);
  assign push_rej   = push_req && !push_ok;
  assign status_clr = MemWriteM && io_sel && (offset == OFF_STATUS) && WriteDataM[7];
  assign cycle_load = MemWriteM && io_sel && (offset == OFF_CYCLE);

  // Head byte is forced to zero while empty so reset leaves tx_data at 0
  assign tx_data = tx_valid ? fifo_mem[rd_ptr_reg] : 8'h00;

  // Next-state computation for FIFO bookkeeping, overflow flag and counter
  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    ovf_next    = ovf_reg;
    cycle_next  = cycle_reg + 32'd1;

    if (push_ok && !pop) begin
      count_next = count_reg + 5'd1;
    end else if (!push_ok && pop) begin
      count_next = count_reg - 5'd1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PW'(1);
    end
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + PW'(1);
    end
    // A rejected push sets ovf even if a clear is requested in the same cycle
    if (push_rej) begin
      ovf_next = 1'b1;
    end else if (status_clr) begin
      ovf_next = 1'b0;
    end
    if (cycle_load) begin
      cycle_next = WriteDataM;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= 5'd0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
      cycle_reg  <= 32'd0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      ovf_reg    <= ovf_next;
      cycle_reg  <= cycle_next;
    end
  end

  // FIFO storage write at the tail pointer
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      fifo_mem[wr_ptr_reg] <= WriteDataM[7:0];
    end
  end

  // Data RAM write; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= WriteDataM;
    end
  end

  // Load data: pure function of address and current state
  always_comb begin
    ReadDataM = 32'd0;
    if (io_sel) begin
      case (offset)
        OFF_STATUS: ReadDataM = {24'd0, ovf_reg, count_reg, full, empty};
        OFF_CYCLE:  ReadDataM = cycle_reg;
        default:    ReadDataM = 32'd0;
      endcase
    end else begin
      ReadDataM = ram[ram_idx];
    end
  end

endmodule

// File: tb/tb_arm_dmem_io.sv
// tb_arm_dmem_io: randomized and directed stimulus against a queue-based
// reference model; a negedge monitor pops expected loads and TX bytes.
module tb_arm_dmem_io;

  localparam int unsigned DW = 64;
  localparam int unsigned FD = 8;
  localparam logic [31:0] IO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_TX  = IO_BASE;
  localparam logic [31:0] A_ST  = IO_BASE + 32'd4;
  localparam logic [31:0] A_CYC = IO_BASE + 32'd8;
  localparam logic [31:0] A_UNM = IO_BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUOutM = 32'd0;
  logic [31:0] WriteDataM = 32'd0;
  logic [31:0] ReadDataM;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  arm_dmem_io #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // Reference model state (as seen during the current cycle)
  logic [31:0] ram_m [int];
  logic [7:0]  fq[$];
  logic        ovf_m = 1'b0;
  logic [31:0] cyc_m = 32'd0;

  // Scoreboard queues
  typedef struct { logic [31:0] addr; logic [31:0] val; } rd_exp_t;
  rd_exp_t     rd_q[$];
  logic [7:0]  tx_exp[$];
  bit          rd_strobe = 1'b0;
  bit          mon_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic bit is_io(input logic [31:0] a);
    return a[31:4] == IO_BASE[31:4];
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int n;
    n = fq.size();
    if (is_io(a)) begin
      case (a[3:2])
        2'd1:    return {24'd0, ovf_m, 5'(n), n == FD, n == 0};
        2'd2:    return cyc_m;
        default: return 32'd0;
      endcase
    end
    return ram_m[int'((a >> 2) % DW)];
  endfunction

  function automatic bit predictable(input logic [31:0] a);
    return is_io(a) || ram_m.exists(int'((a >> 2) % DW));
  endfunction

  // Apply the effect of one clock edge to the model
  function automatic void model_edge(input bit rst, input bit we, input logic [31:0] a,
                                     input logic [31:0] wd, input bit rdy);
    int  n0;
    bit  io, pop;
    logic [1:0] off;
    if (rst) begin
      fq.delete();
      tx_exp.delete();
      ovf_m = 1'b0;
      cyc_m = 32'd0;
      return;
    end
    io  = is_io(a);
    off = a[3:2];
    n0  = fq.size();
    pop = (n0 != 0) && rdy;
    if (we && !io) ram_m[int'((a >> 2) % DW)] = wd;
    if (pop) void'(fq.pop_front());
    if (we && io && off == 2'd0) begin
      if (n0 < FD || pop) begin
        fq.push_back(wd[7:0]);
        tx_exp.push_back(wd[7:0]);
      end else begin
        ovf_m = 1'b1;
      end
    end else if (we && io && off == 2'd1 && wd[7]) begin
      ovf_m = 1'b0;
    end
    cyc_m = (we && io && off == 2'd2) ? wd : cyc_m + 32'd1;
  endfunction

  // One bus cycle: drive after posedge, expect load data, update model after negedge
  task automatic step(input bit rst, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input bit rdy, input bit chk);
    @(posedge clk); #1;
    reset = rst; MemWriteM = we; ALUOutM = a; WriteDataM = wd; tx_ready = rdy;
    rd_strobe = chk && predictable(a);
    if (rd_strobe) rd_q.push_back('{addr: a, val: exp_read(a)});
    @(negedge clk); #1;
    rd_strobe = 1'b0;
    model_edge(rst, we, a, wd, rdy);
  endtask

  // Monitor: compares whatever the DUT presents this cycle against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      check("tx_valid", {31'd0, tx_valid}, {31'd0, fq.size() != 0});
      if (tx_valid === 1'b1 && tx_ready) begin
        if (tx_exp.size() == 0) begin
          check("tx_unexpected_pop", {24'd0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          $display("[TB] pop tx_data=%02h expected=%02h", tx_data, tx_exp[0]);
          check("tx_data", {24'd0, tx_data}, {24'd0, tx_exp.pop_front()});
        end
      end
      if (rd_strobe) begin
        rd_exp_t e;
        e = rd_q.pop_front();
        $display("[TB] load addr=%08h data=%08h expected=%08h", e.addr, ReadDataM, e.val);
        check("read_data", ReadDataM, e.val);
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0, 1: a = IO_BASE + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
      2:    a = $urandom_range(0, 255);
      default: begin
        a = $urandom;
        if (is_io(a)) a = a ^ 32'h8000_0000;
      end
    endcase
    return a;
  endfunction

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    mon_en = 1'b1;

    // Counter after reset and reset state of STATUS
    step(0, 0, A_ST, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, A_CYC, 0, 0, 1);

    // RAM round trip and aliasing
    step(0, 1, 32'h10, 32'hDEAD_BEEF, 0, 0);
    step(0, 0, 32'h10, 0, 0, 1);
    step(0, 0, 32'h13, 0, 0, 1);
    step(0, 0, 32'h110, 0, 0, 1);

    // FIFO ordering
    step(0, 1, A_TX, 32'h41, 0, 1);
    step(0, 1, A_TX, 32'h42, 0, 1);
    step(0, 1, A_TX, 32'h43, 0, 1);
    step(0, 0, A_ST, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, A_ST, 0, 1, 1);
    step(0, 0, A_ST, 0, 0, 1);

    // Overflow then clear
    for (int i = 0; i < 9; i++) step(0, 1, A_TX, 32'h60 + i, 0, 1);
    step(0, 0, A_ST, 0, 0, 1);
    step(0, 1, A_ST, 32'h80, 0, 1);
    step(0, 0, A_ST, 0, 0, 1);

    // Full FIFO: simultaneous push and pop, then drain
    step(0, 1, A_TX, 32'h55, 1, 1);
    step(0, 0, A_ST, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 0, A_ST, 0, 1, 1);

    // Counter load and wrap, unmapped offset
    step(0, 1, A_CYC, 32'hFFFF_FFFE, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, A_CYC, 0, 0, 1);
    step(0, 0, A_UNM, 0, 0, 1);
    step(0, 1, A_UNM, 32'h1234_5678, 0, 1);

    // Reset mid-operation; store during reset ignored
    step(0, 1, 32'h20, 32'h0000_AAAA, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, A_TX, 32'hC0 + i, 0, 0);
    step(1, 1, 32'h20, 32'h0000_5555, 0, 0);
    step(0, 0, A_ST, 0, 0, 1);
    step(0, 0, A_CYC, 0, 0, 1);
    step(0, 0, 32'h10, 0, 0, 1);
    step(0, 0, 32'h20, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), $urandom_range(0, 1), rand_addr(), $urandom,
           $urandom_range(0, 1), 1);
    end

    // Drain, bounded
    for (int i = 0; i < 4 * FD; i++) begin
      if (fq.size() == 0) break;
      step(0, 0, A_ST, 0, 1, 1);
    end
    step(0, 0, A_ST, 0, 1, 1);
    check("tx_bytes_outstanding", tx_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
